// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/op widths, op-select encodings and the packed
// result entry stored by alu_result_buffer.
package alu_pkg;

  localparam int ALU_DW = 8;
  localparam int ALU_SW = 2;

  localparam logic [ALU_SW-1:0] ALU_OP_0 = 2'b00;
  localparam logic [ALU_SW-1:0] ALU_OP_1 = 2'b01;
  localparam logic [ALU_SW-1:0] ALU_OP_2 = 2'b10;
  localparam logic [ALU_SW-1:0] ALU_OP_3 = 2'b11;

  typedef struct packed {
    logic [ALU_SW-1:0] op;
    logic              cout;
    logic [ALU_DW-1:0] data;
  } alu_entry_t;

  localparam int ALU_EW = $bits(alu_entry_t);

endpackage

// File: rtl/result_ram.sv
// DEPTH x W register array for alu_result_buffer: one synchronous write port,
// one asynchronous read port.
module result_ram
  import alu_pkg::*;
#(
  parameter int W     = ALU_EW,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // NOTE: no reset on the array; the pointers alone decide which entries are
  // live, and <= keeps the write ordered against every reader of r_mem.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results {s,cout,f} with valid/ready output and a saturating drop
// counter. Define ALU_RESULT_DEDUP_EN to suppress back-to-back identical pushes.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DW    = ALU_DW,
  parameter int SW    = ALU_SW,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] f,
  input  logic          cout,
  input  logic [SW-1:0] s,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_cout,
  output logic [SW-1:0] out_op,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    drop_count
);

  localparam int           EW       = SW + 1 + DW;
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_param
    $error("alu_result_buffer: DEPTH must be a power of 2 >= 2 and equal 2**AW");
  end

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_drop_count;

  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_rdata;
  logic [AW:0]   w_count_nxt;
  logic          w_pop;
  logic          w_dup;
  logic          w_cand;
  logic          w_push;
  logic          w_drop;

  assign w_in_entry = {s, cout, f};
  assign empty      = (r_count == '0);
  assign full       = (r_count == CNT_FULL);
  assign out_valid  = !empty;
  assign count      = r_count;
  assign drop_count = r_drop_count;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = out_valid && out_ready;
  assign w_cand = in_valid && !w_dup;
  assign w_push = w_cand && (!full || w_pop);
  assign w_drop = w_cand && full && !w_pop;

`ifdef ALU_RESULT_DEDUP_EN
  logic          r_last_vld;
  logic [EW-1:0] r_last_entry;

  assign w_dup = r_last_vld && (w_in_entry == r_last_entry);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_vld   <= 1'b0;
      r_last_entry <= '0;
    end else if (w_push) begin
      r_last_vld   <= 1'b1;
      r_last_entry <= w_in_entry;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  result_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_in_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Uninitialised storage must never leak out while the FIFO is empty.
  assign {out_op, out_cout, out_data} = empty ? '0 : w_rdata;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: queue-based reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] f;
  logic       cout;
  logic [1:0] s;
  logic       in_valid;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_cout;
  logic [1:0] out_op;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic [7:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_entry_t m_q[$];
  int         m_drops    = 0;
  bit         m_last_vld = 1'b0;
  alu_entry_t m_last     = '0;

  always #5 clock = ~clock;

  alu_result_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .f          (f),
    .cout       (cout),
    .s          (s),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_cout   (out_cout),
    .out_op     (out_op),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drops    = 0;
    m_last_vld = 1'b0;
  endtask

  // One clock edge of the FIFO contract, expressed on a queue.
  task automatic model_step();
    alu_entry_t e;
    bit pop;
    bit cand;
    e    = {s, cout, f};
    pop  = (m_q.size() > 0) && out_ready;
    cand = in_valid;
`ifdef ALU_RESULT_DEDUP_EN
    if (m_last_vld && e == m_last) cand = 1'b0;
`endif
    if (cand && m_q.size() == DEPTH && !pop) begin
      if (m_drops < 255) m_drops++;
    end else if (cand) begin
      m_q.push_back(e);
      m_last     = e;
      m_last_vld = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
  endtask

  always @(negedge reset) model_reset();
  always @(posedge clock) if (reset === 1'b1) model_step();

  always @(negedge clock) begin
    alu_entry_t h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    check("cycle",
          {out_valid, empty, full, count, drop_count, out_op, out_cout, out_data},
          {m_q.size() > 0, m_q.size() == 0, m_q.size() == DEPTH,
           4'(m_q.size()), 8'(m_drops), h});
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] fv, input logic cv, input logic [1:0] sv);
    in_valid = v;
    f        = fv;
    cout     = cv;
    s        = sv;
  endtask

  task automatic push(input logic [7:0] fv, input logic cv, input logic [1:0] sv);
    drive(1'b1, fv, cv, sv);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    cyc();
    cyc();
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    f         = '0;
    cout      = 1'b0;
    s         = '0;

    // Reset values and basic flow
    cyc();
    cyc();
    check("rst_empty", empty, 1);
    check("rst_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_data", out_data, 0);
    #2 reset = 1'b1;
    push(8'd20, 1'b0, ALU_OP_0);
    push(8'd50, 1'b0, ALU_OP_1);
    check("basic_count", count, 2);
    check("basic_head", out_data, 20);
    out_ready = 1'b1;
    cyc();
    check("basic_second", out_data, 50);
    check("basic_second_op", out_op, ALU_OP_1);
    cyc();
    check("basic_empty", empty, 1);
    out_ready = 1'b0;

    // Fill and overflow
    for (int i = 1; i <= 10; i++) begin
      push(8'(i), 1'(i), ALU_OP_2);
      if (i == 8) check("fill_full_at_8", full, 1);
    end
    check("fill_count", count, 8);
    check("fill_drops", drop_count, 2);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("fill_drain", out_data, i);
      cyc();
    end
    check("fill_drained_empty", empty, 1);
    out_ready = 1'b0;

    // Full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b0, ALU_OP_1);
    check("sim_full", full, 1);
    drive(1'b1, 8'd99, 1'b1, ALU_OP_3);
    out_ready = 1'b1;
    check("sim_pop_head", out_data, 1);
    cyc();
    in_valid = 1'b0;
    check("sim_count", count, 8);
    check("sim_drops", drop_count, 2);
    for (int i = 0; i < 8; i++) begin
      check("sim_drain", out_data, (i < 7) ? i + 2 : 99);
      cyc();
    end
    check("sim_empty", empty, 1);
    out_ready = 1'b0;

    // Drop counter saturation
    for (int i = 0; i < 8; i++) push(8'(i), 1'b0, ALU_OP_0);
    for (int i = 0; i < 260; i++) push(8'(i + 16), 1'b0, ALU_OP_2);
    check("sat_drops", drop_count, 255);
    check("sat_count", count, 8);

    // Wrap-around with continuous push+pop
    do_reset();
    check("wrap_rst_drops", drop_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b0, ALU_OP_3);
      cyc();
      check("wrap_head", out_data, i);
    end
    in_valid = 1'b0;
    cyc();
    check("wrap_empty", empty, 1);
    out_ready = 1'b0;

    // in_valid low ignores the data inputs
    drive(1'b0, 8'hEE, 1'b1, ALU_OP_3);
    cyc();
    cyc();
    check("idle_ignored", count, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 1'b0, ALU_OP_1);
    check("midrst_held", count, 5);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_drops", drop_count, 0);
    cyc();
    #2 reset = 1'b1;
    push(8'h77, 1'b1, ALU_OP_2);
    check("midrst_count_after", count, 1);
    check("midrst_head", {out_op, out_cout, out_data}, {ALU_OP_2, 1'b1, 8'h77});
    out_ready = 1'b1;
    cyc();
    check("midrst_only_one", empty, 1);
    out_ready = 1'b0;

    // Duplicate suppression
    do_reset();
    push(8'hAA, 1'b0, ALU_OP_3);
    push(8'hAA, 1'b0, ALU_OP_3);
    push(8'hAA, 1'b0, ALU_OP_3);
    push(8'h55, 1'b0, ALU_OP_3);
`ifdef ALU_RESULT_DEDUP_EN
    check("dedup_count", count, 2);
`else
    check("dedup_count", count, 4);
`endif
    check("dedup_drops", drop_count, 0);
    check("dedup_head", out_data, 8'hAA);

    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit ALU. Captures each valid ALU result together with its carry and the op-select that produced it.
- Holds results in a small FIFO and presents them to a consumer through a valid/ready handshake.
- Counts results lost to overflow so the bench and the system can detect back-pressure.

Parameters:
- DW, 8, result data width; matches the ALU f output.
- SW, 2, op-select width; matches the ALU s input.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- AW, 3, pointer width; must equal log2(DEPTH).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- f  in  DW  ALU result.
- cout  in  1  ALU carry out.
- s  in  SW  op-select that produced f/cout.
- in_valid  in  1  f/cout/s are valid this cycle (driven from ALU En).
- out_ready  in  1  consumer accepts the head entry.
- out_valid  out  1  FIFO non-empty; head entry presented.
- out_data  out  DW  head result.
- out_cout  out  1  head carry.
- out_op  out  SW  head op-select.
- count  out  AW+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- drop_count  out  8  results discarded because the FIFO was full; saturating.

Behaviour:
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, drop_count=0.
  - Outputs during reset: out_valid=0, empty=1, full=0. out_data/out_cout/out_op read 0 while empty.
  - Storage array is not cleared.
  - Reset asserted mid-operation discards all held entries immediately; no partial pop completes.
- Push: in_valid=1 and (full=0 or pop in the same cycle). Entry {s,cout,f} is written at wr_ptr and wr_ptr increments.
- Pop: out_valid=1 and out_ready=1 at the rising edge. rd_ptr increments.
- Head presentation:
  - out_data/out_cout/out_op are read combinationally from storage at rd_ptr, gated to 0 when empty.
  - They must remain stable while out_valid=1 and out_ready=0.
- Latency: a result pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass when empty.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- Simultaneous push and pop:
  - When full: both occur, count stays DEPTH, drop_count unchanged.
  - When empty: only the push occurs, because out_valid=0.
- Overflow: in_valid=1, full=1 and no pop. The entry is discarded and drop_count increments, saturating at 255 (no wrap).
- Pointers wrap modulo DEPTH. Entry order is strictly FIFO across wrap.
- in_valid=0: f/cout/s are ignored regardless of their value.
- full and empty are derived from count. Never both 1.

Optional Feature:
- Macro: ALU_RESULT_DEDUP_EN.
- With the macro defined:
  - A 1-bit last_vld flag and a last_entry register track the most recent accepted push.
  - A push is suppressed when last_vld=1 and {s,cout,f} equals last_entry. A suppressed push neither writes nor counts as a drop.
  - last_vld clears on reset. last_entry updates only on an accepted push.
  - Purpose: avoid filling the FIFO while the ALU holds a steady result across many En cycles.
- Without the macro: every in_valid cycle is a push candidate, and no last_entry/last_vld storage exists.

Decomposition:
- Shared package alu_pkg holds:
  - constants ALU_DW=8 and ALU_SW=2;
  - op-select encodings ALU_OP_0..ALU_OP_3 (2'b00..2'b11);
  - a packed result-entry typedef {op, cout, data}, width SW+1+DW.
- Sub-module result_ram: DEPTH x (SW+1+DW) register array with one write port and one asynchronous read port.
- Pointer, count, handshake and drop logic stay in alu_result_buffer.

Test Plan:
- Reset then basic flow:
  - Stimulus: hold reset=0 for 2 cycles, release; push f=20/cout=0/s=00, then f=50/cout=0/s=01, with out_ready=0.
  - Required: count=2. Raise out_ready; head reads 20 then 50 on consecutive cycles; empty=1 after.
- Fill and overflow:
  - Stimulus: out_ready=0; push 10 results f=1..10.
  - Required: full=1 after 8 pushes; drop_count=2; draining yields exactly 1..8.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full with 1..8; out_ready=1 and push f=99 in the same cycle.
  - Required: count stays 8, drop_count unchanged, pop returns 1, and 99 becomes the eighth entry read.
- Wrap-around:
  - Stimulus: 20 cycles of push+pop with f incrementing from 0.
  - Required: outputs appear in order 0..19 with no loss; pointers cross zero at least twice.
- Asynchronous reset mid-stream:
  - Stimulus: 5 entries held; assert reset between clock edges.
  - Required: out_valid=0 and count=0 immediately, without waiting for a clock edge; drop_count=0; the next push after release is the only entry read.
- ALU_RESULT_DEDUP_EN:
  - Stimulus: with the macro defined, push f=0xAA/s=11 three times, then f=0x55/s=11.
  - Required: count=2. Without the macro, the same stimulus gives count=4.
